// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    // Arbiter sequencing: accept in IDLE, access memory in SERVE, acknowledge in RESP.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Identity of the requester that owns the current transaction.
    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_t;

    // Default data-memory depth in words.
    localparam int MEM_WORDS_DEFAULT = 1024;

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported data memory between the CPU MEM stage and a
// debug/loader port. One transaction every three cycles: IDLE -> SERVE -> RESP.
// Optional feature: define DMEM_ARB_RR_EN for round-robin tie-breaking; without it the
// CPU wins every tie.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [31:0] mem_read_data
);

    state_t      state_q, state_d;
    port_t       id_q, id_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        grant_cpu;
    logic        in_range;
`ifdef DMEM_ARB_RR_EN
    port_t       last_q, last_d;
`endif

    assign in_range = (addr_q < 32'(MEM_WORDS));

    // Pick the winner among the requests visible this cycle.
    always_comb begin
        grant_cpu = cpu_req;
`ifdef DMEM_ARB_RR_EN
        if (cpu_req && dbg_req) begin
            grant_cpu = (last_q == PORT_DBG);
        end
`endif
    end

    // Next-state logic: latch the winner in IDLE, capture load data in SERVE.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef DMEM_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    state_d = SERVE;
                    if (grant_cpu) begin
                        id_d    = PORT_CPU;
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end else begin
                        id_d    = PORT_DBG;
                        we_d    = dbg_we;
                        addr_d  = dbg_addr;
                        wdata_d = dbg_wdata;
                    end
`ifdef DMEM_ARB_RR_EN
                    last_d = id_d;
`endif
                end
            end
            SERVE: begin
                rdata_d = (!we_q && in_range) ? mem_read_data : 32'h0;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latch registers; reset discards any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= PORT_CPU;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
`ifdef DMEM_ARB_RR_EN
            last_q  <= PORT_DBG;
`endif
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef DMEM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    // Memory strobes in SERVE, response and ack in RESP, everything else held at zero.
    always_comb begin
        mem_addr       = 32'h0;
        mem_write_data = 32'h0;
        mem_memread    = 1'b0;
        mem_memwrite   = 1'b0;
        cpu_ack        = 1'b0;
        dbg_ack        = 1'b0;
        rsp_rdata      = 32'h0;
        rsp_err        = 1'b0;
        case (state_q)
            SERVE: begin
                mem_addr       = addr_q;
                mem_write_data = wdata_q;
                mem_memread    = !we_q && in_range;
                mem_memwrite   = we_q && in_range && !rst;
            end
            RESP: begin
                cpu_ack   = (id_q == PORT_CPU);
                dbg_ack   = (id_q == PORT_DBG);
                rsp_rdata = rdata_q;
                rsp_err   = !in_range;
            end
            default: begin
            end
        endcase
    end

    assign cpu_stall = cpu_req && !cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed, table-driven bench for dmem_arbiter with a small
// behavioural data memory. Tie expectations follow DMEM_ARB_RR_EN when defined.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic        cpu_ack, cpu_stall, dbg_ack, rsp_err;
    logic [31:0] rsp_rdata, mem_addr, mem_write_data, mem_read_data;
    logic        mem_memwrite, mem_memread;
    logic        mem_init;

    logic [31:0] mem_model [0:1023];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        is_dbg;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_rd;
        logic        exp_wr;
    } vec_t;

    vec_t vecs [13];

    dmem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_ack        (cpu_ack),
        .cpu_stall      (cpu_stall),
        .dbg_req        (dbg_req),
        .dbg_we         (dbg_we),
        .dbg_addr       (dbg_addr),
        .dbg_wdata      (dbg_wdata),
        .dbg_ack        (dbg_ack),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_memwrite   (mem_memwrite),
        .mem_memread    (mem_memread),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Behavioural memory: filled with a recognisable pattern once, then written on strobe.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) begin
                mem_model[i] <= 32'(i) ^ 32'hC0DE0000;
            end
        end else if (mem_memwrite) begin
            mem_model[mem_addr[9:0]] <= mem_write_data;
        end
    end

    assign mem_read_data = mem_model[mem_addr[9:0]];

    // Watchdog so the run always ends even if the DUT wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports any difference.
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic is_dbg, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input logic exp_err, input logic exp_rd, input logic exp_wr);
        vec_t v;
        v.is_dbg    = is_dbg;
        v.we        = we;
        v.addr      = addr;
        v.wdata     = wdata;
        v.exp_rdata = exp_rdata;
        v.exp_err   = exp_err;
        v.exp_rd    = exp_rd;
        v.exp_wr    = exp_wr;
        return v;
    endfunction

    // Drive one request from idle, follow it through SERVE to its ack and check each cycle.
    task automatic apply_stimulus(input vec_t v, input string tag);
        int got;
        logic exp_cpu;
        exp_cpu = !v.is_dbg;
        @(posedge clk); #1;
        cpu_req   = exp_cpu;
        cpu_we    = v.we;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        dbg_req   = v.is_dbg;
        dbg_we    = v.we;
        dbg_addr  = v.addr;
        dbg_wdata = v.wdata;
        got = -1;
        for (int i = 0; i < 8 && got < 0; i++) begin
            @(negedge clk);
            if (cpu_ack || dbg_ack) begin
                got = i;
                check_output({tag, " cpu_ack"}, 32'(cpu_ack), 32'(exp_cpu));
                check_output({tag, " dbg_ack"}, 32'(dbg_ack), 32'(v.is_dbg));
                check_output({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
                check_output({tag, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
                check_output({tag, " ack stall"}, 32'(cpu_stall), 32'b0);
                check_output({tag, " ack strobes"}, {30'b0, mem_memread, mem_memwrite}, 32'b0);
            end else begin
                check_output({tag, " wait stall"}, 32'(cpu_stall), 32'(exp_cpu));
                check_output({tag, " idle rsp"}, {31'b0, rsp_err} | rsp_rdata, 32'b0);
                if (i == 0) begin
                    check_output({tag, " idle mem_addr"}, mem_addr, 32'h0);
                end
                if (i == 1) begin
                    check_output({tag, " serve mem_addr"}, mem_addr, v.addr);
                    check_output({tag, " serve wdata"}, mem_write_data, v.wdata);
                    check_output({tag, " serve memread"}, 32'(mem_memread), 32'(v.exp_rd));
                    check_output({tag, " serve memwrite"}, 32'(mem_memwrite), 32'(v.exp_wr));
                end
            end
        end
        check_output({tag, " latency"}, 32'(got), 32'd2);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        @(posedge clk); #1;
        rst     = 1'b1;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Main sequence: reset, vector table, continuous tie, reset during a store.
    initial begin
        logic [3:0] tie_cpu;
        int cyc;
        int nack;

        rst = 1'b1; mem_init = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;

        vecs[0]  = mk(1'b0, 1'b1, 32'd5,          32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b1);
        vecs[1]  = mk(1'b0, 1'b0, 32'd5,          32'h0,        32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        vecs[2]  = mk(1'b1, 1'b1, 32'd9,          32'h12345678, 32'h0,        1'b0, 1'b0, 1'b1);
        vecs[3]  = mk(1'b1, 1'b0, 32'd9,          32'h0,        32'h12345678, 1'b0, 1'b1, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 32'd1024,       32'h0,        32'h0,        1'b1, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 32'd2000,       32'hCAFEF00D, 32'h0,        1'b1, 1'b0, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 32'd976,        32'h0,        32'hC0DE03D0, 1'b0, 1'b1, 1'b0);
        vecs[7]  = mk(1'b0, 1'b1, 32'd1023,       32'hA5A5A5A5, 32'h0,        1'b0, 1'b0, 1'b1);
        vecs[8]  = mk(1'b1, 1'b0, 32'd1023,       32'h0,        32'hA5A5A5A5, 1'b0, 1'b1, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 32'd100,        32'h0,        32'hC0DE0064, 1'b0, 1'b1, 1'b0);
        vecs[10] = mk(1'b0, 1'b1, 32'd7,          32'h00000077, 32'h0,        1'b0, 1'b0, 1'b1);
        vecs[11] = mk(1'b0, 1'b0, 32'hFFFFFFFF,   32'h0,        32'h0,        1'b1, 1'b0, 1'b0);
        vecs[12] = mk(1'b1, 1'b0, 32'd0,          32'h0,        32'hC0DE0000, 1'b0, 1'b1, 1'b0);

        // Reset held for two cycles: every output must read zero.
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        check_output("reset acks", {30'b0, cpu_ack, dbg_ack}, 32'b0);
        check_output("reset strobes", {30'b0, mem_memread, mem_memwrite}, 32'b0);
        check_output("reset rsp_rdata", rsp_rdata, 32'h0);
        check_output("reset rsp_err", 32'(rsp_err), 32'b0);
        check_output("reset mem_addr", mem_addr, 32'h0);
        check_output("reset stall", 32'(cpu_stall), 32'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int k = 0; k < 13; k++) begin
            apply_stimulus(vecs[k], $sformatf("vec%0d", k));
        end

        // Continuous tie of two loads; the last-grant pointer starts at DBG after reset.
`ifdef DMEM_ARB_RR_EN
        tie_cpu = 4'b0101;
`else
        tie_cpu = 4'b1111;
`endif
        apply_reset(2);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd5;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd9;
        cyc = 0;
        nack = 0;
        while (nack < 4 && cyc < 20) begin
            @(negedge clk);
            if (cpu_ack || dbg_ack) begin
                check_output("tie ack cycle", 32'(cyc), 32'(2 + 3 * nack));
                check_output("tie cpu_ack", 32'(cpu_ack), 32'(tie_cpu[nack]));
                check_output("tie dbg_ack", 32'(dbg_ack), 32'(!tie_cpu[nack]));
                check_output("tie rsp_rdata", rsp_rdata, tie_cpu[nack] ? 32'hDEADBEEF : 32'h12345678);
                nack++;
            end
            cyc++;
        end
        check_output("tie ack count", 32'(nack), 32'd4);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        dbg_req = 1'b0;

        // Reset arriving during SERVE of a store must suppress the write and the ack.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd7; cpu_wdata = 32'h1;
        @(negedge clk);
        check_output("midrst idle stall", 32'(cpu_stall), 32'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        check_output("midrst memwrite", 32'(mem_memwrite), 32'b0);
        check_output("midrst serve addr", mem_addr, 32'd7);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("midrst no ack", {30'b0, cpu_ack, dbg_ack}, 32'b0);
        end
        apply_stimulus(mk(1'b0, 1'b0, 32'd7, 32'h0, 32'h00000077, 1'b0, 1'b1, 1'b0), "midrst load");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 MEM_WORDS, default 1024, number of data-memory words; any address >= MEM_WORDS is out of range.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cpu_req  in  1  MEM-stage request; held high with cpu_we/cpu_addr/cpu_wdata stable until cpu_ack.
REQ-005 cpu_we  in  1  CPU request type: 1=store, 0=load.
REQ-006 cpu_addr  in  32  CPU word address.
REQ-007 cpu_wdata  in  32  CPU store data.
REQ-008 cpu_ack  out  1  one-cycle CPU completion pulse.
REQ-009 cpu_stall  out  1  pipeline freeze, equal to cpu_req AND NOT cpu_ack.
REQ-010 dbg_req  in  1  debug/loader request; same hold rules as cpu_req.
REQ-011 dbg_we  in  1  debug request type: 1=store, 0=load.
REQ-012 dbg_addr  in  32  debug word address.
REQ-013 dbg_wdata  in  32  debug store data.
REQ-014 dbg_ack  out  1  one-cycle debug completion pulse.
REQ-015 rsp_rdata  out  32  load data shared by both ports; valid only in the ack cycle.
REQ-016 rsp_err  out  1  out-of-range flag; valid only in the ack cycle.
REQ-017 mem_addr  out  32  data-memory address.
REQ-018 mem_write_data  out  32  data-memory write data.
REQ-019 mem_memwrite  out  1  data-memory write strobe, committed at the rising edge.
REQ-020 mem_memread  out  1  data-memory read enable.
REQ-021 mem_read_data  in  32  data-memory combinational read data.

Function
REQ-022 FSM states: IDLE, SERVE, RESP.
- IDLE: if any request is high, latch the winner's id, we, addr and wdata, then go to SERVE.
- Otherwise IDLE stays in IDLE.
REQ-023 SERVE lasts exactly one cycle, during which the FSM:
- drives mem_addr and mem_write_data from the latch;
- registers mem_read_data into rsp_rdata (load, in range);
- goes to RESP.
REQ-024 RESP lasts one cycle: assert only the winner's ack together with rsp_rdata/rsp_err, then go to IDLE.
REQ-025 Latency and throughput:
- Request sampled at the end of IDLE cycle N gives ack in cycle N+2.
- One transaction per 3 cycles maximum.
REQ-026 Strobe equations:
- mem_memread = SERVE AND NOT we AND in-range.
- mem_memwrite = SERVE AND we AND in-range AND NOT rst.
- mem_addr and mem_write_data = 0 outside SERVE.
REQ-027 Out-of-range address: no strobe asserted; ack still issued with rsp_err=1 and rsp_rdata=0.
REQ-028 Store completion: rsp_rdata=0 and rsp_err=0 in the ack cycle.
REQ-029 Outside RESP: rsp_rdata=0, rsp_err=0, both acks 0.
REQ-030 A request dropped after it is latched still completes; requests arriving during SERVE/RESP wait for IDLE.
REQ-031 Tie (both requests high in IDLE): resolved per REQ-034/REQ-035.

Reset
REQ-032 rst in any state gives, on the next edge:
- FSM in IDLE;
- latch cleared;
- all outputs 0;
- in-flight transaction discarded with no ack.
REQ-033 No memory write commits at an edge where rst is high, including mid-SERVE.

Configuration
REQ-034 With DMEM_ARB_RR_EN defined, round-robin applies:
- A tie goes to the port not granted last.
- The last-grant pointer resets to DBG, so CPU wins the first tie.
REQ-035 Without DMEM_ARB_RR_EN, fixed priority applies: CPU always wins ties and DBG may starve.

Structure
REQ-036 Package dmem_arb_pkg holds:
- the state typedef (IDLE/SERVE/RESP);
- the port-id typedef (PORT_CPU/PORT_DBG);
- the default MEM_WORDS constant.
REQ-037 Single flat module; no sub-module.

Verification
REQ-038 Bench scenarios, each stimulus followed by its required response:
- Reset: rst held 2 cycles -> all acks, strobes, rsp_rdata and rsp_err are 0; FSM in IDLE.
- Store then load: CPU store addr 5 data 0xDEADBEEF -> one-cycle mem_memwrite with mem_addr=5; CPU load addr 5 -> cpu_ack 2 cycles after sample, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Continuous tie: CPU and DBG loads held continuously -> without macro, only cpu_ack pulses; with DMEM_ARB_RR_EN, acks alternate CPU, DBG, CPU, DBG.
- Out of range: DBG load addr 1024 -> mem_memread stays 0; dbg_ack with rsp_err=1, rsp_rdata=0.
- Reset mid-write: rst asserted during SERVE of CPU store addr 7 data 0x1 -> mem_memwrite 0, no cpu_ack; a later load of addr 7 returns the prior value.
- Stall: cpu_stall=1 from cpu_req rise until the cpu_ack cycle, where it is 0.
